// File: rtl/comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
// Holds the FSM state encoding, result bit positions and the parameter legality check.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    localparam int unsigned CMP_LT = 0;
    localparam int unsigned CMP_EQ = 1;
    localparam int unsigned CMP_GT = 2;
    localparam int unsigned CMP_W  = 3;

    // Operand width must split into whole digits of legal size.
    function automatic bit width_ok(input int unsigned width, input int unsigned digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational DIGIT-wide unsigned magnitude compare; exactly one of lt/gt/eq is high.
module comparator_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSD-first magnitude comparator behind valid/ready, early exit on first unequal digit.
// Optional two's-complement mode enabled by the SIGNED_CMP_EN macro (adds the in_signed port).
module seq_mag_comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
    input  logic             in_signed,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             LT,
    output logic             GT,
    output logic             EQ
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0]    IDX_TOP  = IW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
        $error("seq_mag_comparator: WIDTH must be a nonzero multiple of DIGIT");
    end

    cmp_state_t       state, state_d;
    logic [IW-1:0]    idx, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CMP_W-1:0] res_q, res_d;
    logic [WIDTH-1:0] flip;
    logic             dig_lt, dig_gt, dig_eq;

`ifdef SIGNED_CMP_EN
    assign flip = in_signed ? MSB_MASK : '0;
`else
    assign flip = '0;
`endif

    // Operands shift left each equal step, so the active digit is always the top slice.
    comparator_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_q[WIDTH-1 -: DIGIT]),
        .b  (b_q[WIDTH-1 -: DIGIT]),
        .lt (dig_lt),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= IDX_TOP;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a ^ flip;
                    b_d     = b ^ flip;
                    idx_d   = IDX_TOP;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dig_gt) begin
                    res_d         = '0;
                    res_d[CMP_GT] = 1'b1;
                    state_d       = DONE;
                end else if (dig_lt) begin
                    res_d         = '0;
                    res_d[CMP_LT] = 1'b1;
                    state_d       = DONE;
                end else if (dig_eq && (idx == '0)) begin
                    res_d         = '0;
                    res_d[CMP_EQ] = 1'b1;
                    state_d       = DONE;
                end else begin
                    idx_d = idx - IW'(1);
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    res_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                res_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign LT = res_q[CMP_LT];
    assign GT = res_q[CMP_GT];
    assign EQ = res_q[CMP_EQ];

endmodule
